// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS main controller FSM
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   op, funct      IR[31:26] and IR[5:0]
//   zero, upover   ALU equality and signed-add overflow flags
//   pc_wr, pc_src  PC load enable and source select
//   ir_wr, iord    IR load enable, memory address select
//   mem_wr         memory write strobe
//   reg_wr, reg_dst, mem_to_reg  register file write controls
//   alu_src_a, alu_src_b, ext_op, alu_ctr  ALU operand and function select
//   state          current state, exposed for debug
module mc_ctrl_fsm #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            upover,
    output logic            pc_wr,
    output logic [1:0]      pc_src,
    output logic            ir_wr,
    output logic            iord,
    output logic            mem_wr,
    output logic            reg_wr,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            ext_op,
    output logic [1:0]      alu_ctr,
    output logic [ST_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_SLT  = 2'b11;

    typedef enum logic [ST_W-1:0] {
        S_IDLE,
        S_FETCH,
        S_DCD,
        S_EXE_R,
        S_EXE_I,
        S_ALU_WB,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   ov_q;
    logic   r_legal;

    assign r_legal = (op == OP_RTYPE) &&
                     ((funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_SLT));
    assign state   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Overflow of addi is latched at the end of EXE_I so that ALU_WB can
    // suppress the register write; FETCH clears it for the next instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
        end else if (state_q == S_FETCH) begin
            ov_q <= 1'b0;
        end else if (state_q == S_EXE_I) begin
            ov_q <= upover & (op == OP_ADDI);
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_wr      = 1'b0;
        pc_src     = 2'b00;
        ir_wr      = 1'b0;
        iord       = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        alu_ctr    = ALU_ADD;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_wr     = 1'b1;
                alu_src_b = 2'b01;
                pc_wr     = 1'b1;
                state_d   = S_DCD;
            end
            S_DCD: begin
                // ALU computes PC + (sext imm << 2) so ALUOut holds the
                // branch target by the time BRANCH needs it.
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                if (r_legal) begin
                    state_d = S_EXE_R;
                end else if ((op == OP_ORI) || (op == OP_ADDI)) begin
                    state_d = S_EXE_I;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    state_d = S_MEM_ADR;
                end else if (op == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (op == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXE_R: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                case (funct)
                    FN_SUBU: alu_ctr = ALU_SUB;
                    FN_SLT:  alu_ctr = ALU_SLT;
                    default: alu_ctr = ALU_ADD;
                endcase
                state_d = S_ALU_WB;
            end
            S_EXE_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (op == OP_ORI) begin
                    ext_op  = 1'b0;
                    alu_ctr = ALU_OR;
                end else begin
                    ext_op  = 1'b1;
                    alu_ctr = ALU_ADD;
                end
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                mem_to_reg = 1'b0;
                reg_dst    = (op == OP_RTYPE);
                reg_wr     = ~ov_q;
                state_d    = S_FETCH;
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                state_d   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord    = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                iord    = 1'b1;
                mem_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_ctr   = ALU_SUB;
                pc_src    = 2'b01;
                // Mealy output: follows the ALU compare within this cycle.
                pc_wr     = zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_wr   = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                // Unused encodings recover through FETCH with all outputs low.
                state_d = S_FETCH;
            end
        endcase
    end

endmodule
